regfile_scoreboard: RTL and testbench

- Decode-stage consumer of the writeback interface. Holds the 32x32 RV32I integer register file and accepts writeback's regWrite/rd/writeData.
- Serves two combinational read ports to decode.
- Keeps a per-register scoreboard of in-flight writes (issued, not yet retired) and raises a decode stall when a source register is still pending.
- Sits between the decode stage (issue side) and the writeback stage (retire side).

---
 rtl/regfile_scoreboard.sv | 113 +++++++++++
 tb/tb_regfile_scoreboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// RV32I integer register file with a per-register scoreboard of in-flight writes.
// Define REGFILE_BYPASS_EN to enable same-cycle write-through of the retiring value.
module regfile_scoreboard #(
  parameter int MAX_PENDING = 3,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            writeBack_in_regWrite,
  input  logic [4:0]      writeBack_in_rd,
  input  logic [XLEN-1:0] writeBack_in_writeData,
  input  logic [4:0]      decode_in_rs1,
  input  logic [4:0]      decode_in_rs2,
  input  logic            decode_in_rs1_used,
  input  logic            decode_in_rs2_used,
  input  logic            decode_in_issue,
  input  logic            decode_in_issue_regWrite,
  input  logic [4:0]      decode_in_issue_rd,
  input  logic            kill0_in_valid,
  input  logic [4:0]      kill0_in_rd,
  input  logic            kill1_in_valid,
  input  logic [4:0]      kill1_in_rd,
  output logic [XLEN-1:0] decode_out_rs1_data,
  output logic [XLEN-1:0] decode_out_rs2_data,
  output logic            decode_out_stall,
  output logic            sb_out_overflow,
  output logic            sb_out_underflow
);

  localparam int CW = $clog2(MAX_PENDING + 1);

  logic [XLEN-1:0] regs [32];
  logic [CW-1:0]   cnt [32];
  logic [CW-1:0]   cnt_next [32];
  logic            ovf_set;
  logic            unf_set;
  int              sum;
  logic            wb_live;

  assign wb_live = writeBack_in_regWrite && (writeBack_in_rd != 5'd0);

  // All events on a register are summed first; only the net change saturates.
  always_comb begin
    cnt_next = cnt;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    sum      = 0;
    for (int r = 1; r < 32; r++) begin
      sum = int'(cnt[r])
          + int'(decode_in_issue && decode_in_issue_regWrite && (decode_in_issue_rd == 5'(r)))
          - int'(writeBack_in_regWrite && (writeBack_in_rd == 5'(r)))
          - int'(kill0_in_valid && (kill0_in_rd == 5'(r)))
          - int'(kill1_in_valid && (kill1_in_rd == 5'(r)));
      if (sum > MAX_PENDING) begin
        cnt_next[r] = CW'(MAX_PENDING);
        ovf_set     = 1'b1;
      end else if (sum < 0) begin
        cnt_next[r] = '0;
        unf_set     = 1'b1;
      end else begin
        cnt_next[r] = CW'(sum);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      sb_out_overflow  <= 1'b0;
      sb_out_underflow <= 1'b0;
    end else begin
      if (wb_live) regs[writeBack_in_rd] <= writeBack_in_writeData;
      cnt <= cnt_next;
      if (ovf_set) sb_out_overflow <= 1'b1;
      if (unf_set) sb_out_underflow <= 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;

  // rst_n gating keeps read data at zero while reset is held.
  assign hit1 = rst_n && wb_live && (writeBack_in_rd == decode_in_rs1);
  assign hit2 = rst_n && wb_live && (writeBack_in_rd == decode_in_rs2);

  always_comb begin
    decode_out_rs1_data = regs[decode_in_rs1];
    decode_out_rs2_data = regs[decode_in_rs2];
    if (hit1) decode_out_rs1_data = writeBack_in_writeData;
    if (hit2) decode_out_rs2_data = writeBack_in_writeData;
    if (decode_in_rs1 == 5'd0) decode_out_rs1_data = '0;
    if (decode_in_rs2 == 5'd0) decode_out_rs2_data = '0;
  end

  assign decode_out_stall = (decode_in_rs1_used && (cnt[decode_in_rs1] > CW'(hit1)))
                         || (decode_in_rs2_used && (cnt[decode_in_rs2] > CW'(hit2)));
`else
  always_comb begin
    decode_out_rs1_data = regs[decode_in_rs1];
    decode_out_rs2_data = regs[decode_in_rs2];
    if (decode_in_rs1 == 5'd0) decode_out_rs1_data = '0;
    if (decode_in_rs2 == 5'd0) decode_out_rs2_data = '0;
  end

  assign decode_out_stall = (decode_in_rs1_used && (cnt[decode_in_rs1] != '0))
                         || (decode_in_rs2_used && (cnt[decode_in_rs2] != '0));
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic against a reference model.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_used;
  logic        rs2_used;
  logic        issue;
  logic        issue_we;
  logic [4:0]  issue_rd;
  logic        k0_valid;
  logic [4:0]  k0_rd;
  logic        k1_valid;
  logic [4:0]  k1_rd;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;
  logic        overflow;
  logic        underflow;

  int tests_run;
  int tests_failed;

  logic [31:0] model_regs [32];
  int          model_cnt [32];
  logic        model_ovf;
  logic        model_unf;

  regfile_scoreboard dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .writeBack_in_regWrite    (wb_we),
    .writeBack_in_rd          (wb_rd),
    .writeBack_in_writeData   (wb_data),
    .decode_in_rs1            (rs1),
    .decode_in_rs2            (rs2),
    .decode_in_rs1_used       (rs1_used),
    .decode_in_rs2_used       (rs2_used),
    .decode_in_issue          (issue),
    .decode_in_issue_regWrite (issue_we),
    .decode_in_issue_rd       (issue_rd),
    .kill0_in_valid           (k0_valid),
    .kill0_in_rd              (k0_rd),
    .kill1_in_valid           (k1_valid),
    .kill1_in_rd              (k1_rd),
    .decode_out_rs1_data      (rs1_data),
    .decode_out_rs2_data      (rs2_data),
    .decode_out_stall         (stall),
    .sb_out_overflow          (overflow),
    .sb_out_underflow         (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < 32; r++) begin
      model_regs[r] = '0;
      model_cnt[r]  = 0;
    end
    model_ovf = 1'b0;
    model_unf = 1'b0;
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_rd == rs) return wb_data;
`endif
    return model_regs[rs];
  endfunction

  function automatic int expPending(input logic [4:0] rs);
    int e;
    e = model_cnt[rs];
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_rd == rs && rs != 5'd0) e = e - 1;
`endif
    return e;
  endfunction

  // Apply one full set of inputs for a cycle, check outputs, then advance the model at the edge.
  task automatic applyStimulus(
    input logic w_we, input logic [4:0] w_rd, input logic [31:0] w_data,
    input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
    input logic iss, input logic iss_we, input logic [4:0] iss_rd,
    input logic kv0, input logic [4:0] kr0, input logic kv1, input logic [4:0] kr1);
    int n;
    logic exp_stall;
    @(negedge clk);
    wb_we = w_we; wb_rd = w_rd; wb_data = w_data;
    rs1 = r1; rs2 = r2; rs1_used = u1; rs2_used = u2;
    issue = iss; issue_we = iss_we; issue_rd = iss_rd;
    k0_valid = kv0; k0_rd = kr0; k1_valid = kv1; k1_rd = kr1;
    #1;
    exp_stall = (u1 && expPending(r1) > 0) || (u2 && expPending(r2) > 0);
    checkOutput("rs1_data", rs1_data, expRead(r1));
    checkOutput("rs2_data", rs2_data, expRead(r2));
    checkOutput("stall", {31'b0, stall}, {31'b0, exp_stall});
    checkOutput("overflow", {31'b0, overflow}, {31'b0, model_ovf});
    checkOutput("underflow", {31'b0, underflow}, {31'b0, model_unf});
    @(posedge clk);
    if (w_we && w_rd != 5'd0) model_regs[w_rd] = w_data;
    for (int r = 1; r < 32; r++) begin
      n = model_cnt[r];
      if (iss && iss_we && iss_rd == 5'(r)) n++;
      if (w_we && w_rd == 5'(r)) n--;
      if (kv0 && kr0 == 5'(r)) n--;
      if (kv1 && kr1 == 5'(r)) n--;
      if (n > 3) begin
        model_cnt[r] = 3;
        model_ovf = 1'b1;
      end else if (n < 0) begin
        model_cnt[r] = 0;
        model_unf = 1'b1;
      end else begin
        model_cnt[r] = n;
      end
    end
  endtask

  task automatic idleRead(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
    applyStimulus(0, 0, 0, r1, r2, u1, u2, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issueTo(input logic [4:0] rd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, rd, 0, 0, 0, 0);
  endtask

  task automatic retire(input logic [4:0] rd, input logic [31:0] data, input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
    applyStimulus(1, rd, data, r1, r2, u1, u2, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    issue = 0; issue_we = 0; issue_rd = 0;
    k0_valid = 0; k0_rd = 0; k1_valid = 0; k1_rd = 0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_rs1", rs1_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 32; r++) idleRead(5'(r), 5'(31 - r), 1, 1);

    // Retire with bypass, then from storage, then a discarded write to x0.
    retire(7, 32'hDEADBEEF, 7, 0, 1, 0);
    idleRead(7, 7, 1, 1);
    retire(0, 32'h1234, 0, 0, 1, 1);
    idleRead(0, 7, 0, 0);

    issueTo(3);
    idleRead(0, 3, 0, 1);
    retire(3, 32'h0000_3333, 0, 3, 0, 1);
    idleRead(0, 3, 0, 1);

    issueTo(9);
    applyStimulus(1, 9, 32'h99, 9, 0, 1, 0, 1, 1, 9, 0, 0, 0, 0);
    idleRead(9, 0, 1, 0);

    repeat (4) issueTo(4);
    idleRead(4, 0, 1, 0);
    applyStimulus(0, 0, 0, 4, 0, 1, 0, 0, 0, 0, 1, 4, 1, 4);
    idleRead(4, 0, 1, 0);

    retire(12, 32'hC0FFEE12, 12, 0, 1, 0);
    idleRead(12, 12, 1, 1);

    // Asynchronous reset while x5 has two writes pending.
    issueTo(5);
    issueTo(5);
    @(negedge clk);
    wb_we = 0; issue = 0; k0_valid = 0; k1_valid = 0;
    rs1 = 5; rs1_used = 1; rs2 = 7; rs2_used = 0;
    #1;
    checkOutput("pre_reset_stall", {31'b0, stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("async_reset_rs2", rs2_data, 32'd0);
    checkOutput("async_reset_ovf", {31'b0, overflow}, 32'd0);
    checkOutput("async_reset_unf", {31'b0, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic concentrated on a few registers to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                    $urandom_range(0, 9) == 0, 5'($urandom_range(0, 7)),
                    $urandom_range(0, 9) == 0, 5'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
